instr_fetch_decode: RTL and testbench

Fetch/decode stage of the PDP-8 pipeline. It sits directly upstream of the EXEC unit. It reads each instruction word from `memory_pdp` at the current PC, decodes it into `pdp_mem_opcode_s` / `pdp_op7_opcode_s`, and computes the effective address. It presents the decoded instruction to EXEC and holds it until EXEC's `stall` handshake completes, then fetches again at the PC that EXEC returns.

---
 rtl/instr_fetch_decode.sv | 189 ++++++++++++++++++
 tb/tb_instr_fetch_decode.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_decode.sv
// PDP-8 fetch/decode stage: fetches at PC, decodes into EXEC structs, computes EA.
// Optional indirect addressing is enabled by defining PDP8_INDIRECT_ADDR_EN.

package pdp8_pkg;
  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 12;

  typedef struct packed {
    logic                  AND;
    logic                  TAD;
    logic                  ISZ;
    logic                  DCA;
    logic                  JMS;
    logic                  JMP;
    logic [ADDR_WIDTH-1:0] mem_inst_addr;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic NOP;
    logic CLA_CLL;
  } pdp_op7_opcode_s;
endpackage

module instr_fetch_decode #(
  parameter int                     ADDR_WIDTH    = pdp8_pkg::ADDR_WIDTH,
  parameter int                     DATA_WIDTH    = pdp8_pkg::DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]  START_ADDRESS = 12'o0200
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic [ADDR_WIDTH-1:0]     PC_value,
  output logic                      ifu_rd_req,
  output logic [ADDR_WIDTH-1:0]     ifu_rd_addr,
  input  logic [DATA_WIDTH-1:0]     ifu_rd_data,
  output logic [ADDR_WIDTH-1:0]     base_addr,
  output pdp8_pkg::pdp_mem_opcode_s pdp_mem_opcode,
  output pdp8_pkg::pdp_op7_opcode_s pdp_op7_opcode,
  output logic                      halted
);

  typedef enum logic [3:0] {
    IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    DECODE,
`ifdef PDP8_INDIRECT_ADDR_EN
    IND_REQ,
    IND_WAIT,
`endif
    ISSUE,
    WAIT_EXEC,
    HALT
  } state_t;

  state_t                    state, next_state;
  logic [ADDR_WIDTH-1:0]     pc;
  logic [DATA_WIDTH-1:0]     ir;
  logic [2:0]                opcode;
  logic                      i_bit, p_bit, is_mem_ref, is_hlt;
  logic [6:0]                offset;
  logic [ADDR_WIDTH-1:0]     ea;
  pdp8_pkg::pdp_mem_opcode_s dec_mem;
  pdp8_pkg::pdp_op7_opcode_s dec_op7;
`ifdef PDP8_INDIRECT_ADDR_EN
  logic                      is_ind;
  pdp8_pkg::pdp_mem_opcode_s ind_op, ind_issue;
`endif

  assign base_addr  = START_ADDRESS;
  assign halted     = (state == HALT);
  assign opcode     = ir[11:9];
  assign i_bit      = ir[8];
  assign p_bit      = ir[7];
  assign offset     = ir[6:0];
  assign is_mem_ref = (opcode <= 3'd5);
  // Page-bit EA always uses the PC the instruction was fetched from.
  assign ea         = p_bit ? {pc[ADDR_WIDTH-1:7], offset} : {{(ADDR_WIDTH-7){1'b0}}, offset};

  always_comb begin
    dec_mem = '0;
    dec_op7 = '0;
    is_hlt  = 1'b0;
    if (is_mem_ref) begin
      case (opcode)
        3'd0:    dec_mem.AND = 1'b1;
        3'd1:    dec_mem.TAD = 1'b1;
        3'd2:    dec_mem.ISZ = 1'b1;
        3'd3:    dec_mem.DCA = 1'b1;
        3'd4:    dec_mem.JMS = 1'b1;
        default: dec_mem.JMP = 1'b1;
      endcase
      dec_mem.mem_inst_addr = ea;
`ifndef PDP8_INDIRECT_ADDR_EN
      if (i_bit) dec_mem = '0;
`endif
    end else if (opcode == 3'd7) begin
      dec_op7.CLA_CLL = (ir == 12'o7300);
      dec_op7.NOP     = (ir == 12'o7000);
      is_hlt          = (ir == 12'o7402);
    end
  end

`ifdef PDP8_INDIRECT_ADDR_EN
  assign is_ind = is_mem_ref & i_bit;
  always_comb begin
    ind_issue               = ind_op;
    ind_issue.mem_inst_addr = ifu_rd_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    ifu_rd_req  = 1'b0;
    ifu_rd_addr = '0;
    case (state)
      IDLE:       next_state = FETCH_REQ;
      FETCH_REQ: begin
        ifu_rd_req  = 1'b1;
        ifu_rd_addr = pc;
        next_state  = FETCH_WAIT;
      end
      FETCH_WAIT: next_state = DECODE;
      DECODE: begin
        if (is_hlt)      next_state = HALT;
`ifdef PDP8_INDIRECT_ADDR_EN
        else if (is_ind) next_state = IND_REQ;
`endif
        else             next_state = ISSUE;
      end
`ifdef PDP8_INDIRECT_ADDR_EN
      IND_REQ: begin
        ifu_rd_req  = 1'b1;
        ifu_rd_addr = ea;
        next_state  = IND_WAIT;
      end
      IND_WAIT:   next_state = ISSUE;
`endif
      ISSUE:      if (stall)  next_state = WAIT_EXEC;
      WAIT_EXEC:  if (!stall) next_state = FETCH_REQ;
      HALT:       next_state = HALT;
      default:    next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= START_ADDRESS;
      ir             <= '0;
      pdp_mem_opcode <= '0;
      pdp_op7_opcode <= '0;
`ifdef PDP8_INDIRECT_ADDR_EN
      ind_op         <= '0;
`endif
    end else begin
      case (state)
        FETCH_WAIT: ir <= ifu_rd_data;
        DECODE: begin
`ifdef PDP8_INDIRECT_ADDR_EN
          // Indirect decodes stay hidden until the pointer word arrives.
          if (is_ind) begin
            ind_op         <= dec_mem;
            pdp_mem_opcode <= '0;
          end else
`endif
          pdp_mem_opcode <= dec_mem;
          pdp_op7_opcode <= dec_op7;
        end
`ifdef PDP8_INDIRECT_ADDR_EN
        IND_WAIT: pdp_mem_opcode <= ind_issue;
`endif
        WAIT_EXEC: begin
          if (!stall) begin
            pc             <= PC_value;
            pdp_mem_opcode <= '0;
            pdp_op7_opcode <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Randomized self-checking bench for instr_fetch_decode against a decode reference model.
// Expectations follow PDP8_INDIRECT_ADDR_EN the same way the design does.

module tb_instr_fetch_decode;
  import pdp8_pkg::*;

`ifdef PDP8_INDIRECT_ADDR_EN
  localparam bit IND_EN = 1'b1;
`else
  localparam bit IND_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            stall = 1'b0;
  logic [11:0]     PC_value = '0;
  logic            ifu_rd_req;
  logic [11:0]     ifu_rd_addr;
  logic [11:0]     ifu_rd_data = '0;
  logic [11:0]     base_addr;
  pdp_mem_opcode_s pdp_mem_opcode;
  pdp_op7_opcode_s pdp_op7_opcode;
  logic            halted;

  logic [11:0] mem [0:4095];
  int assertions = 0;
  int failures   = 0;

  instr_fetch_decode dut (
    .clk(clk), .reset(reset), .stall(stall), .PC_value(PC_value),
    .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr), .ifu_rd_data(ifu_rd_data),
    .base_addr(base_addr), .pdp_mem_opcode(pdp_mem_opcode),
    .pdp_op7_opcode(pdp_op7_opcode), .halted(halted)
  );

  always #5 clk = ~clk;

  // Memory answers one cycle after a request; otherwise drives junk.
  always @(posedge clk) begin
    if (ifu_rd_req) ifu_rd_data <= mem[ifu_rd_addr];
    else            ifu_rd_data <= 12'($urandom);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [11:0] effAddr(input int instr, input int pc);
    int off;
    off = instr % 128;
    if (((instr / 128) % 2) == 1) return 12'((pc / 128) * 128 + off);
    return 12'(off);
  endfunction

  // Reference decode from the instruction word in bench memory.
  task automatic refDecode(input logic [11:0] pc, output pdp_mem_opcode_s m, output pdp_op7_opcode_s o,
                           output bit hlt, output bit ind, output logic [11:0] ea);
    int instr, op, ib;
    instr = int'(mem[pc]);
    op    = instr / 512;
    ib    = (instr / 256) % 2;
    m = '0; o = '0; hlt = 1'b0; ind = 1'b0;
    ea = effAddr(instr, int'(pc));
    if (op <= 5) begin
      if (ib == 0 || IND_EN) begin
        case (op)
          0: m.AND = 1'b1;
          1: m.TAD = 1'b1;
          2: m.ISZ = 1'b1;
          3: m.DCA = 1'b1;
          4: m.JMS = 1'b1;
          default: m.JMP = 1'b1;
        endcase
        m.mem_inst_addr = (ib == 1) ? mem[ea] : ea;
        ind = (ib == 1);
      end
    end else if (instr == 'o7300) o.CLA_CLL = 1'b1;
    else if (instr == 'o7000) o.NOP = 1'b1;
    else if (instr == 'o7402) hlt = 1'b1;
  endtask

  function automatic logic [11:0] genInstr();
    logic [11:0] w;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: w = 12'($urandom_range(0, 5) * 512 + $urandom_range(0, 511));
      6: w = 12'('o6000 + $urandom_range(0, 511));
      7: w = 12'o7300;
      8: w = 12'o7000;
      default: begin
        w = 12'('o7000 + $urandom_range(0, 511));
        if (w == 12'o7000 || w == 12'o7300 || w == 12'o7402) w = 12'o7040;
      end
    endcase
    return w;
  endfunction

  task automatic applyStimulus(input logic [11:0] pc, input logic [11:0] instr, input logic [11:0] ptr);
    logic [11:0] ea;
    mem[pc] = instr;
    ea = effAddr(int'(instr), int'(pc));
    if (instr < 12'o6000 && ea != pc) mem[ea] = ptr;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_req",    32'(ifu_rd_req), 32'd0);
    checkOutput("rst_addr",   32'(ifu_rd_addr), 32'd0);
    checkOutput("rst_base",   32'(base_addr), 32'o0200);
    checkOutput("rst_mem",    32'(pdp_mem_opcode), 32'd0);
    checkOutput("rst_op7",    32'(pdp_op7_opcode), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
  endtask

  // Entered just before the negedge on which the fetch request must be visible.
  task automatic runInstr(input logic [11:0] pc, input int stallLen,
                          input logic [11:0] nPc, input logic [11:0] nInstr, input logic [11:0] nPtr);
    pdp_mem_opcode_s em;
    pdp_op7_opcode_s eo;
    bit hlt, ind;
    logic [11:0] ea;
    refDecode(pc, em, eo, hlt, ind, ea);
    @(negedge clk);
    checkOutput("fetch_req",  32'(ifu_rd_req), 32'd1);
    checkOutput("fetch_addr", 32'(ifu_rd_addr), 32'(pc));
    checkOutput("fetch_mem_clear", 32'(pdp_mem_opcode), 32'd0);
    checkOutput("fetch_op7_clear", 32'(pdp_op7_opcode), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      stall = 1'($urandom_range(0, 1));
      checkOutput("req_gap", 32'(ifu_rd_req), 32'd0);
    end
    if (ind) begin
      @(negedge clk);
      stall = 1'($urandom_range(0, 1));
      checkOutput("ind_req",  32'(ifu_rd_req), 32'd1);
      checkOutput("ind_addr", 32'(ifu_rd_addr), 32'(ea));
      @(negedge clk);
      stall = 1'($urandom_range(0, 1));
      checkOutput("ind_gap", 32'(ifu_rd_req), 32'd0);
    end
    @(negedge clk);
    stall = 1'b0;
    checkOutput("dec_mem",    32'(pdp_mem_opcode), 32'(em));
    checkOutput("dec_op7",    32'(pdp_op7_opcode), 32'(eo));
    checkOutput("dec_halted", 32'(halted), 32'(hlt));
    checkOutput("issue_req",  32'(ifu_rd_req), 32'd0);
    if (hlt) begin
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        stall = 1'($urandom_range(0, 1));
        checkOutput("halt_req",    32'(ifu_rd_req), 32'd0);
        checkOutput("halt_flag",   32'(halted), 32'd1);
        checkOutput("halt_struct", 32'(pdp_mem_opcode), 32'd0);
      end
      stall = 1'b0;
      return;
    end
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      checkOutput("issue_hold", 32'(pdp_mem_opcode), 32'(em));
      checkOutput("issue_req",  32'(ifu_rd_req), 32'd0);
    end
    applyStimulus(nPc, nInstr, nPtr);
    stall = 1'b1;
    repeat (stallLen) begin
      @(negedge clk);
      PC_value = 12'($urandom);
      checkOutput("stall_hold_mem", 32'(pdp_mem_opcode), 32'(em));
      checkOutput("stall_hold_op7", 32'(pdp_op7_opcode), 32'(eo));
      checkOutput("stall_req",      32'(ifu_rd_req), 32'd0);
    end
    PC_value = nPc;
    stall    = 1'b0;
  endtask

  task automatic resetMid(input logic [11:0] pc);
    @(negedge clk);
    checkOutput("rm_fetch_req",  32'(ifu_rd_req), 32'd1);
    checkOutput("rm_fetch_addr", 32'(ifu_rd_addr), 32'(pc));
    repeat (IND_EN ? 4 : 1) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkResetValues();
    applyStimulus(12'o0200, 12'o7402, 12'o0000);
    reset = 1'b0;
  endtask

  initial begin
    logic [11:0] cur, nxt, nInstr;
    for (int i = 0; i < 4096; i++) mem[i] = 12'($urandom);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkResetValues();
    applyStimulus(12'o0200, 12'o1050, 12'o0000);
    reset = 1'b0;
    runInstr(12'o0200, 5, 12'o0201, 12'o5377, 12'o0000);
    runInstr(12'o0201, 5, 12'o0202, 12'o1450, 12'o1234);
    runInstr(12'o0202, 3, 12'o7777, 12'o1377, 12'($urandom));
    runInstr(12'o7777, 2, 12'o0000, 12'o3577, 12'($urandom));
    cur = 12'o0000;
    for (int i = 0; i < 40; i++) begin
      nxt    = 12'($urandom);
      nInstr = (i == 39) ? 12'('o1400 + $urandom_range(0, 255)) : genInstr();
      runInstr(cur, $urandom_range(1, 5), nxt, nInstr, 12'($urandom));
      cur = nxt;
    end
    resetMid(cur);
    runInstr(12'o0200, 1, 12'o0000, 12'o0000, 12'o0000);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
